match_controller: RTL and testbench

- Parametrised successor to the two-tank game-state FSM: runs a full multi-round match for NUM_TANKS tanks.
- Tracks which tanks are alive, detects the round winner or a draw, and keeps per-tank scores.
- Inserts a frame-timed pause after each round, requests a new maze, and declares the match winner at WIN_SCORE.
- Sits between keyboard/collision logic and the maze generator and renderer.

---
 rtl/match_pkg.sv | 22 ++
 rtl/survivor_encoder.sv | 27 ++
 rtl/match_controller.sv | 165 ++++++++++++++++
 tb/tb_match_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and constants for the multi-tank match controller.
package match_pkg;

  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    START_WAIT = 3'd1,
    PLAYING    = 3'd2,
    ROUND_OVER = 3'd3,
    MATCH_OVER = 3'd4
  } match_state_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;

  // Enter may appear in any of the four packed keycode slots.
  function automatic logic has_enter(input logic [31:0] kc);
    has_enter = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (kc[b*8 +: 8] == KEY_ENTER) has_enter = 1'b1;
    end
  endfunction

endpackage

// File: rtl/survivor_encoder.sv
// Counts the survivors of a round and encodes the index of a lone survivor.
module survivor_encoder #(
  parameter int NUM_TANKS = 2
) (
  input  logic [NUM_TANKS-1:0] alive_n,
  output logic                 count_is_one,
  output logic                 count_is_zero,
  output logic [1:0]           idx
);

  logic [2:0] cnt;

  // idx tracks the highest set bit; it is only meaningful when exactly one is set.
  always_comb begin
    cnt = 3'd0;
    idx = 2'd0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      if (alive_n[i]) begin
        cnt = cnt + 3'd1;
        idx = 2'(i);
      end
    end
    count_is_one  = (cnt == 3'd1);
    count_is_zero = (cnt == 3'd0);
  end

endmodule

// File: rtl/match_controller.sv
// Multi-round match sequencer: tracks survivors, scores rounds, paces the
// inter-round pause on frame ticks and requests fresh mazes.
module match_controller
  import match_pkg::*;
#(
  parameter int NUM_TANKS   = 2,
  parameter int WIN_SCORE   = 5,
  parameter int ROUND_DELAY = 120,
  parameter int SCORE_W     = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         frame_tick,
  input  logic [31:0]                  keycode,
  input  logic [NUM_TANKS-1:0]         tank_shot,
  input  logic                         maze_ready,
  output logic                         title,
  output logic                         playing,
  output logic                         round_over,
  output logic                         match_over,
  output logic                         maze_regen,
  output logic [NUM_TANKS-1:0]         alive,
  output logic [1:0]                   round_winner,
  output logic                         round_draw,
  output logic [NUM_TANKS*SCORE_W-1:0] scores
);

  localparam int DLY_W = (ROUND_DELAY < 2) ? 1 : $clog2(ROUND_DELAY);
  localparam logic [DLY_W-1:0]     DLY_LAST  = DLY_W'(ROUND_DELAY - 1);
  localparam logic [SCORE_W-1:0]   WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [NUM_TANKS-1:0] ALL_ALIVE = '1;

  match_state_t           state_q, state_d;
  logic [NUM_TANKS-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]     score_q [NUM_TANKS];
  logic [SCORE_W-1:0]     score_d [NUM_TANKS];
  logic [1:0]             winner_q, winner_d;
  logic                   draw_q, draw_d;
  logic [DLY_W-1:0]       delay_q, delay_d;
  logic                   regen_q, regen_d;
  logic                   enter_prev_q;

  logic                   enter_now, enter_edge, any_win;
  logic [NUM_TANKS-1:0]   alive_n;
  logic                   count_is_one, count_is_zero;
  logic [1:0]             surv_idx;

  assign enter_now  = has_enter(keycode);
  assign enter_edge = enter_now & ~enter_prev_q;
  assign alive_n    = alive_q & ~tank_shot;

  survivor_encoder #(.NUM_TANKS(NUM_TANKS)) u_surv (
    .alive_n       (alive_n),
    .count_is_one  (count_is_one),
    .count_is_zero (count_is_zero),
    .idx           (surv_idx)
  );

  always_comb begin
    any_win = 1'b0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      if (score_q[i] == WIN) any_win = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    alive_d  = alive_q;
    score_d  = score_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    delay_d  = delay_q;
    regen_d  = 1'b0;
    unique case (state_q)
      TITLE: begin
        if (enter_edge) begin
          for (int i = 0; i < NUM_TANKS; i++) score_d[i] = '0;
          winner_d = 2'd0;
          draw_d   = 1'b0;
          regen_d  = 1'b1;
          alive_d  = ALL_ALIVE;
          state_d  = START_WAIT;
        end
      end
      START_WAIT: begin
        alive_d = ALL_ALIVE;
        if (maze_ready) state_d = PLAYING;
      end
      PLAYING: begin
        if (count_is_one) begin
          winner_d = surv_idx;
          draw_d   = 1'b0;
          for (int i = 0; i < NUM_TANKS; i++) begin
            if (surv_idx == 2'(i) && score_q[i] < WIN) score_d[i] = score_q[i] + SCORE_W'(1);
          end
          delay_d = '0;
          state_d = ROUND_OVER;
        end else if (count_is_zero) begin
          draw_d  = 1'b1;
          delay_d = '0;
          state_d = ROUND_OVER;
        end else begin
          alive_d = alive_n;
        end
      end
      ROUND_OVER: begin
        if (frame_tick) begin
          if (delay_q == DLY_LAST) begin
            if (any_win) begin
              state_d = MATCH_OVER;
            end else begin
              regen_d = 1'b1;
              alive_d = ALL_ALIVE;
              state_d = START_WAIT;
            end
          end else begin
            delay_d = delay_q + DLY_W'(1);
          end
        end
      end
      MATCH_OVER: begin
        if (enter_edge) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= TITLE;
      alive_q      <= ALL_ALIVE;
      winner_q     <= 2'd0;
      draw_q       <= 1'b0;
      delay_q      <= '0;
      regen_q      <= 1'b0;
      enter_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
      delay_q      <= delay_d;
      regen_q      <= regen_d;
      enter_prev_q <= enter_now;
    end
  end

  for (genvar gi = 0; gi < NUM_TANKS; gi++) begin : g_score
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) score_q[gi] <= '0;
      else          score_q[gi] <= score_d[gi];
    end
    assign scores[gi*SCORE_W +: SCORE_W] = score_q[gi];
  end

  assign title        = (state_q == TITLE);
  assign playing      = (state_q == PLAYING);
  assign round_over   = (state_q == ROUND_OVER);
  assign match_over   = (state_q == MATCH_OVER);
  assign maze_regen   = regen_q;
  assign alive        = alive_q;
  assign round_winner = winner_q;
  assign round_draw   = draw_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller against a behavioural match model.
module tb_match_controller;

  localparam int NT = 3;
  localparam int WS = 2;
  localparam int RD = 3;
  localparam int SW = 4;

  localparam int M_TITLE = 0, M_WAIT = 1, M_PLAY = 2, M_ROVER = 3, M_MOVER = 4;

  logic           CLK = 1'b0;
  logic           RESET_N;
  logic           frame_tick;
  logic [31:0]    keycode;
  logic [NT-1:0]  tank_shot;
  logic           maze_ready;
  logic           title, playing, round_over, match_over, maze_regen;
  logic [NT-1:0]  alive;
  logic [1:0]     round_winner;
  logic           round_draw;
  logic [NT*SW-1:0] scores;

  always #5 CLK = ~CLK;

  match_controller #(.NUM_TANKS(NT), .WIN_SCORE(WS), .ROUND_DELAY(RD), .SCORE_W(SW)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .frame_tick   (frame_tick),
    .keycode      (keycode),
    .tank_shot    (tank_shot),
    .maze_ready   (maze_ready),
    .title        (title),
    .playing      (playing),
    .round_over   (round_over),
    .match_over   (match_over),
    .maze_regen   (maze_regen),
    .alive        (alive),
    .round_winner (round_winner),
    .round_draw   (round_draw),
    .scores       (scores)
  );

  typedef struct packed {
    logic           title;
    logic           playing;
    logic           round_over;
    logic           match_over;
    logic           regen;
    logic [NT-1:0]  alive;
    logic [1:0]     winner;
    logic           draw;
    logic [NT*SW-1:0] scores;
  } snap_t;

  snap_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Behavioural match model: phase, survivors, scoreboard and pause frames.
  int       m_phase;
  int       m_score [NT];
  int       m_winner;
  int       m_frames;
  bit       m_draw, m_regen, m_eprev;
  bit [NT-1:0] m_alive;

  function automatic void model_reset();
    m_phase  = M_TITLE;
    for (int i = 0; i < NT; i++) m_score[i] = 0;
    m_winner = 0;
    m_frames = 0;
    m_draw   = 0;
    m_regen  = 0;
    m_eprev  = 0;
    m_alive  = '1;
  endfunction

  function automatic void model_step(input logic [31:0] key, input logic [NT-1:0] shot,
                                     input bit mr, input bit ft);
    bit enter_now;
    bit press;
    bit [NT-1:0] left;
    int n;
    bool_champ: begin end
    enter_now = 0;
    for (int b = 0; b < 4; b++) if (key[b*8 +: 8] == 8'h28) enter_now = 1;
    press   = enter_now && !m_eprev;
    m_eprev = enter_now;
    m_regen = 0;
    case (m_phase)
      M_TITLE: if (press) begin
        for (int i = 0; i < NT; i++) m_score[i] = 0;
        m_winner = 0;
        m_draw   = 0;
        m_regen  = 1;
        m_alive  = '1;
        m_phase  = M_WAIT;
      end
      M_WAIT: begin
        m_alive = '1;
        if (mr) m_phase = M_PLAY;
      end
      M_PLAY: begin
        left = m_alive & ~shot;
        n = $countones(left);
        if (n == 1) begin
          for (int i = 0; i < NT; i++) if (left[i]) m_winner = i;
          m_draw = 0;
          if (m_score[m_winner] < WS) m_score[m_winner]++;
          m_frames = 0;
          m_phase  = M_ROVER;
        end else if (n == 0) begin
          m_draw   = 1;
          m_frames = 0;
          m_phase  = M_ROVER;
        end else begin
          m_alive = left;
        end
      end
      M_ROVER: if (ft) begin
        m_frames++;
        if (m_frames == RD) begin
          n = 0;
          for (int i = 0; i < NT; i++) if (m_score[i] == WS) n++;
          if (n > 0) m_phase = M_MOVER;
          else begin
            m_regen = 1;
            m_alive = '1;
            m_phase = M_WAIT;
          end
        end
      end
      default: if (press) m_phase = M_TITLE;
    endcase
  endfunction

  function automatic snap_t model_snapshot();
    snap_t s;
    s.title      = (m_phase == M_TITLE);
    s.playing    = (m_phase == M_PLAY);
    s.round_over = (m_phase == M_ROVER);
    s.match_over = (m_phase == M_MOVER);
    s.regen      = m_regen;
    s.alive      = m_alive;
    s.winner     = 2'(m_winner);
    s.draw       = m_draw;
    s.scores     = '0;
    for (int i = 0; i < NT; i++) s.scores[i*SW +: SW] = SW'(m_score[i]);
    return s;
  endfunction

  function automatic logic [31:0] rand_keys(input bit with_enter);
    logic [31:0] kc;
    int v;
    int pos;
    for (int b = 0; b < 4; b++) begin
      v = $urandom_range(0, 254);
      if (v >= 8'h28) v++;
      kc[b*8 +: 8] = 8'(v);
    end
    if (with_enter) begin
      pos = $urandom_range(0, 3);
      kc[pos*8 +: 8] = 8'h28;
    end
    return kc;
  endfunction

  task automatic step(input bit rst, input logic [31:0] key, input logic [NT-1:0] shot,
                      input bit mr, input bit ft);
    @(negedge CLK);
    keycode    = key;
    tank_shot  = shot;
    maze_ready = mr;
    frame_tick = ft;
    if (rst) begin
      RESET_N = 1'b0;
      model_reset();
    end else begin
      RESET_N = 1'b1;
      model_step(key, shot, mr, ft);
    end
    exp_q.push_back(model_snapshot());
  endtask

  // Monitor: one expected snapshot per clock edge, popped just after the edge.
  initial begin
    snap_t e, a, prev;
    prev = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {title, playing, round_over, match_over, maze_regen, alive, round_winner, round_draw, scores};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got tprm=%b%b%b%b regen=%b alive=%b win=%0d draw=%b scores=%h, expected tprm=%b%b%b%b regen=%b alive=%b win=%0d draw=%b scores=%h",
                   $time, a.title, a.playing, a.round_over, a.match_over, a.regen, a.alive, a.winner, a.draw, a.scores,
                   e.title, e.playing, e.round_over, e.match_over, e.regen, e.alive, e.winner, e.draw, e.scores);
        end else if (e[$bits(snap_t)-1 -: 5] != prev[$bits(snap_t)-1 -: 5]) begin
          $display("[%0t] tprm=%b%b%b%b regen=%b alive=%b winner=%0d draw=%b scores=%h ok",
                   $time, e.title, e.playing, e.round_over, e.match_over, e.regen, e.alive, e.winner, e.draw, e.scores);
        end
        prev = e;
      end
    end
  end

  initial begin
    int hold;
    bit rst;
    logic [NT-1:0] shot;
    RESET_N    = 1'b0;
    keycode    = '0;
    tank_shot  = '0;
    maze_ready = 1'b0;
    frame_tick = 1'b0;
    model_reset();

    // Directed opening: reset, held Enter, a three-hit round, reset during the pause.
    repeat (3) step(1, 32'h0, '0, 0, 0);
    repeat (10) step(0, 32'h0000_2800, '0, 0, 0);
    repeat (2) step(0, 32'h0, '0, 1, 0);
    step(0, 32'h0, 3'b001, 0, 0);
    step(0, 32'h0, 3'b001, 0, 0);
    step(0, 32'h0, 3'b100, 0, 0);
    repeat (2) step(0, 32'h0, '0, 0, 1);
    step(1, 32'h0, '0, 0, 0);
    step(0, 32'h0, '0, 0, 0);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (hold == 0 && $urandom_range(0, 19) == 0) hold = $urandom_range(1, 6);
      shot = ($urandom_range(0, 3) == 0) ? NT'($urandom_range(1, (1 << NT) - 1)) : '0;
      step(rst, rand_keys(hold > 0), shot, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      if (hold > 0) hold--;
    end

    repeat (3) @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
